// File: rtl/cond_branch_unit_pkg.sv
// Shared definitions for the conditional branch unit and its condition decoder:
// condition codes, flag bit positions, FSM state encoding and the debug struct.
package cond_branch_unit_pkg;

  localparam int PC_W_DEFAULT = 16;

  // Condition codes carried by br_cond
  localparam logic [2:0] COND_AL = 3'b000;  // always
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_GE = 3'b011;
  localparam logic [2:0] COND_LT = 3'b100;
  localparam logic [2:0] COND_GT = 3'b101;  // ge & ne
  localparam logic [2:0] COND_LE = 3'b110;  // lt | eq
  localparam logic [2:0] COND_NV = 3'b111;  // never

  // Bit positions inside the 4-bit comparator flag vector
  localparam int FLAG_EQ = 3;
  localparam int FLAG_NE = 2;
  localparam int FLAG_GE = 1;
  localparam int FLAG_LT = 0;

  // Branch FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Internal state made visible for checkers and debug
  typedef struct packed {
    logic [1:0] state;
    logic       flags_ok;
  } cbu_dbg_t;

  // AL and NV resolve without looking at the flags
  function automatic logic cond_needs_flags(input logic [2:0] cond);
    return !((cond == COND_AL) || (cond == COND_NV));
  endfunction

endpackage

// File: rtl/cond_branch_unit_cond_eval.sv
// Combinational condition decoder: comparator flags + condition code -> taken.
// Shared with the instruction decoder, so it carries no state.
module cond_eval
  import cond_branch_unit_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] cond,
  output logic       taken
);

  // Map each condition code onto the flag bits it depends on
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = flags[FLAG_EQ];
      COND_NE: taken = flags[FLAG_NE];
      COND_GE: taken = flags[FLAG_GE];
      COND_LT: taken = flags[FLAG_LT];
      COND_GT: taken = flags[FLAG_GE] & flags[FLAG_NE];
      COND_LE: taken = flags[FLAG_LT] | flags[FLAG_EQ];
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_branch_unit.sv
// Conditional branch resolution: holds the latest comparator flags, accepts a
// branch request, waits for fresh flags when needed and presents taken/pc_next
// to fetch.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. br_ready depends only on internal state (high in IDLE); res_valid is high
// in DONE and taken/pc_next stay frozen until res_ready is sampled high. The
// producer must hold its payload while valid is high and not yet accepted.
module cond_branch_unit
  import cond_branch_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      flags_in,
  input  logic            flags_we,
  input  logic            cmp_start,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_offset,
  input  logic [PC_W-1:0] pc_in,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            taken,
  output logic [PC_W-1:0] pc_next,
  output logic [3:0]      flags_q,
  output cbu_dbg_t        dbg
);

  logic [1:0]      state;
  logic            flags_ok;
  logic [2:0]      cond_r;
  logic [PC_W-1:0] off_r;
  logic [PC_W-1:0] pc_r;

  logic            bypass;
  logic            flags_avail;
  logic [3:0]      eff_flags;
  logic            accept;
  logic            resolve_now;
  logic            resolve_wait;

  logic [2:0]      eval_cond;
  logic [3:0]      eval_flags;
  logic [PC_W-1:0] eval_pc;
  logic [PC_W-1:0] eval_off;
  logic            eval_taken;
  logic [PC_W-1:0] eval_pc_next;

  // Flag availability: fresh flags this cycle bypass the register; a cmp_start
  // makes the stored flags stale immediately, even in the cycle it arrives.
  always_comb begin
    bypass      = flags_we & ~cmp_start;
    flags_avail = bypass | (flags_ok & ~cmp_start);
    eff_flags   = bypass ? flags_in : flags_q;
  end

  // Handshake and resolve decisions
  always_comb begin
    br_ready     = (state == ST_IDLE);
    res_valid    = (state == ST_DONE);
    accept       = br_ready & br_valid;
    resolve_now  = accept & (~cond_needs_flags(br_cond) | flags_avail);
    resolve_wait = (state == ST_WAIT) & bypass;
  end

  // Evaluate either the incoming request (IDLE) or the parked one (WAIT)
  always_comb begin
    if (state == ST_IDLE) begin
      eval_cond  = br_cond;
      eval_flags = eff_flags;
      eval_pc    = pc_in;
      eval_off   = br_offset;
    end else begin
      eval_cond  = cond_r;
      eval_flags = flags_in;
      eval_pc    = pc_r;
      eval_off   = off_r;
    end
  end

  cond_eval u_cond_eval (
    .flags (eval_flags),
    .cond  (eval_cond),
    .taken (eval_taken)
  );

  // Target arithmetic wraps modulo 2^PC_W
  always_comb begin
    eval_pc_next = eval_taken ? (eval_pc + eval_off) : (eval_pc + PC_W'(1));
  end

  // Flag register and its freshness bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= 4'b0000;
      flags_ok <= 1'b0;
    end else begin
      if (flags_we) begin
        flags_q <= flags_in;
      end
      if (bypass) begin
        flags_ok <= 1'b1;
      end else if (cmp_start) begin
        flags_ok <= 1'b0;
      end
    end
  end

  // Branch FSM: IDLE -> (WAIT) -> DONE -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (resolve_now) begin
            state <= ST_DONE;
          end else if (accept) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (resolve_wait) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture the request on accept so later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_r <= COND_AL;
      off_r  <= '0;
      pc_r   <= '0;
    end else if (accept) begin
      cond_r <= br_cond;
      off_r  <= br_offset;
      pc_r   <= pc_in;
    end
  end

  // Result registers, written only when a branch resolves and held in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken   <= 1'b0;
      pc_next <= '0;
    end else if (resolve_now || resolve_wait) begin
      taken   <= eval_taken;
      pc_next <= eval_pc_next;
    end
  end

  // Debug view of internal state
  always_comb begin
    dbg.state    = state;
    dbg.flags_ok = flags_ok;
  end

endmodule

// File: tb/tb_cond_branch_unit.sv
// Bench for cond_branch_unit: directed vector table, hand-written multi-cycle
// sequences, then random traffic against an operand-level reference model.
module tb_cond_branch_unit;
  import cond_branch_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  flags_in = '0;
  logic        flags_we = 1'b0;
  logic        cmp_start = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_ready;
  logic [2:0]  br_cond = '0;
  logic [15:0] br_offset = '0;
  logic [15:0] pc_in = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        taken;
  logic [15:0] pc_next;
  logic [3:0]  flags_q;
  cbu_dbg_t    dbg;

  always #5 clk = ~clk;

  cond_branch_unit #(.PC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flags_in(flags_in), .flags_we(flags_we),
    .cmp_start(cmp_start), .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_offset(br_offset), .pc_in(pc_in),
    .res_valid(res_valid), .res_ready(res_ready), .taken(taken),
    .pc_next(pc_next), .flags_q(flags_q), .dbg(dbg)
  );

  int total = 0;
  int bad = 0;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flags_we = 0; cmp_start = 0; br_valid = 0; res_ready = 0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_res(input string name);
    int n = 0;
    while (!res_valid && n < 10) begin
      tick();
      n++;
    end
    if (!res_valid) check({name, "_timeout"}, 0, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  flags;
    logic [2:0]  cond;
    logic [15:0] pc;
    logic [15:0] off;
    logic        exp_taken;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[14];

  // ---------------- reference model (operand level) ----------------
  function automatic logic cond_holds(input logic [2:0] c,
                                      input logic signed [15:0] a,
                                      input logic signed [15:0] b);
    case (c)
      3'd0: return 1'b1;
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return a >= b;
      3'd4: return a < b;
      3'd5: return a > b;
      3'd6: return a <= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] flags_of(input logic signed [15:0] a,
                                          input logic signed [15:0] b);
    return {a == b, a != b, a >= b, a < b};
  endfunction

  bit                 m_res, m_pend, m_fresh, m_written;
  logic               m_taken;
  logic [15:0]        m_pc;
  logic [2:0]         p_cond;
  logic [15:0]        p_pc, p_off;
  logic signed [15:0] la, lb;

  function automatic logic signed [15:0] rnd_operand();
    logic signed [15:0] v;
    if ($urandom_range(0, 9) < 7) v = 16'($signed($urandom_range(0, 6)) - 3);
    else v = 16'($urandom);
    return v;
  endfunction

  initial begin
    // --- table fill ---
    vecs[0]  = '{4'b1010, 3'b001, 16'h0100, 16'hFFF0, 1'b1, 16'h00F0};
    vecs[1]  = '{4'b1010, 3'b100, 16'h0100, 16'hFFF0, 1'b0, 16'h0101};
    vecs[2]  = '{4'b0000, 3'b000, 16'h0010, 16'h0005, 1'b1, 16'h0015};
    vecs[3]  = '{4'b0101, 3'b111, 16'hFFFF, 16'h0003, 1'b0, 16'h0000};
    vecs[4]  = '{4'b0101, 3'b000, 16'hFFFE, 16'h0004, 1'b1, 16'h0002};
    vecs[5]  = '{4'b0110, 3'b101, 16'h0200, 16'h0010, 1'b1, 16'h0210};
    vecs[6]  = '{4'b1010, 3'b101, 16'h0200, 16'h0010, 1'b0, 16'h0201};
    vecs[7]  = '{4'b0101, 3'b110, 16'h0300, 16'hFF00, 1'b1, 16'h0200};
    vecs[8]  = '{4'b0110, 3'b110, 16'h0300, 16'hFF00, 1'b0, 16'h0301};
    vecs[9]  = '{4'b1010, 3'b010, 16'h0400, 16'h0002, 1'b0, 16'h0401};
    vecs[10] = '{4'b1010, 3'b011, 16'h0400, 16'h0002, 1'b1, 16'h0402};
    vecs[11] = '{4'b0101, 3'b011, 16'h0400, 16'h0002, 1'b0, 16'h0401};
    vecs[12] = '{4'b0110, 3'b010, 16'h8000, 16'h8000, 1'b1, 16'h0000};
    vecs[13] = '{4'b0101, 3'b100, 16'h1234, 16'h0010, 1'b1, 16'h1244};

    // --- reset state ---
    do_reset();
    check("rst_br_ready", br_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_taken", taken, 0);
    check("rst_pc_next", pc_next, 0);
    check("rst_flags_q", flags_q, 0);
    check("rst_flags_ok", dbg.flags_ok, 0);
    check("rst_state", dbg.state, ST_IDLE);

    // --- table: odd entries write flags first, even entries use the bypass ---
    for (int i = 0; i < 14; i++) begin
      if (i % 2 == 1) begin
        flags_we = 1; flags_in = vecs[i].flags;
        tick();
        flags_we = 0;
      end
      br_valid = 1; br_cond = vecs[i].cond; pc_in = vecs[i].pc; br_offset = vecs[i].off;
      if (i % 2 == 0) begin
        flags_we = 1; flags_in = vecs[i].flags;
      end
      check($sformatf("vec%0d_br_ready", i), br_ready, 1);
      tick();
      br_valid = 0; flags_we = 0;
      exp_q.push_back({15'd0, vecs[i].exp_taken, vecs[i].exp_pc});
      check($sformatf("vec%0d_res_valid", i), res_valid, 1);
      check($sformatf("vec%0d_result", i), {15'd0, taken, pc_next}, exp_q.pop_front());
      res_ready = 1;
      tick();
      res_ready = 0;
    end

    // --- stale flags: branch waits, cmp_start in WAIT keeps it waiting ---
    cmp_start = 1;
    tick();
    cmp_start = 0;
    br_valid = 1; br_cond = 3'b101; pc_in = 16'h0200; br_offset = 16'h0010;
    tick();
    br_valid = 0; br_cond = 3'b000; pc_in = 16'hFFFF; br_offset = 16'h1111;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("wait%0d_br_ready", k), br_ready, 0);
      check($sformatf("wait%0d_res_valid", k), res_valid, 0);
      cmp_start = (k == 1);
      tick();
      cmp_start = 0;
    end
    flags_we = 1; flags_in = 4'b0110;
    tick();
    flags_we = 0;
    check("wait_res_valid", res_valid, 1);
    check("wait_taken", taken, 1);
    check("wait_pc_next", pc_next, 16'h0210);

    // --- hold in DONE while res_ready low; no accept in DONE ---
    br_valid = 1; br_cond = 3'b000; pc_in = 16'h0000; br_offset = 16'h0001;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("hold%0d_res_valid", k), res_valid, 1);
      check($sformatf("hold%0d_result", k), {taken, pc_next}, {1'b1, 16'h0210});
      check($sformatf("hold%0d_br_ready", k), br_ready, 0);
    end
    res_ready = 1;
    tick();
    res_ready = 0; br_valid = 0;
    check("release_br_ready", br_ready, 1);
    check("release_res_valid", res_valid, 0);

    // --- asynchronous reset while a branch waits ---
    cmp_start = 1;
    tick();
    cmp_start = 0;
    br_valid = 1; br_cond = 3'b001; pc_in = 16'h0500; br_offset = 16'h0008;
    tick();
    br_valid = 0;
    check("pre_rst_state", dbg.state, ST_WAIT);
    rst_n = 0;
    #2;
    check("mid_rst_br_ready", br_ready, 1);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_taken", taken, 0);
    check("mid_rst_pc_next", pc_next, 0);
    check("mid_rst_flags_q", flags_q, 0);
    check("mid_rst_flags_ok", dbg.flags_ok, 0);
    #2;
    rst_n = 1;
    tick();
    br_valid = 1; br_cond = 3'b001; pc_in = 16'h0500; br_offset = 16'h0008;
    tick();
    br_valid = 0;
    check("post_rst_wait_br_ready", br_ready, 0);
    tick();
    check("post_rst_wait_res_valid", res_valid, 0);
    flags_we = 1; flags_in = 4'b1010;
    tick();
    flags_we = 0;
    check("post_rst_res_valid", res_valid, 1);
    check("post_rst_result", {taken, pc_next}, {1'b1, 16'h0508});
    res_ready = 1;
    tick();
    res_ready = 0;

    // --- random traffic vs operand-level model ---
    do_reset();
    m_res = 0; m_pend = 0; m_fresh = 0; m_written = 0;
    m_taken = 0; m_pc = 0; la = 0; lb = 0;
    for (int c = 0; c < 600; c++) begin
      logic               we, cs, bv, rr, byp, avail;
      logic signed [15:0] a, b, ca, cb;
      logic [2:0]         cnd;
      logic [15:0]        pc, off;
      we = ($urandom_range(0, 9) < 3);
      cs = ($urandom_range(0, 9) < 2);
      bv = $urandom_range(0, 1);
      rr = $urandom_range(0, 1);
      a = rnd_operand();
      b = rnd_operand();
      cnd = 3'($urandom_range(0, 7));
      pc = 16'($urandom);
      off = 16'($urandom);
      flags_we = we; cmp_start = cs; flags_in = flags_of(a, b);
      br_valid = bv; br_cond = cnd; pc_in = pc; br_offset = off; res_ready = rr;
      check("rnd_br_ready", br_ready, {31'd0, !m_res && !m_pend});

      byp = we && !cs;
      avail = byp || (m_fresh && !cs);
      ca = byp ? a : la;
      cb = byp ? b : lb;
      if (m_res) begin
        if (rr) m_res = 0;
      end else if (m_pend) begin
        if (byp) begin
          m_taken = cond_holds(p_cond, a, b);
          m_pc = m_taken ? p_pc + p_off : p_pc + 16'd1;
          m_res = 1; m_pend = 0;
        end
      end else if (bv) begin
        if (cnd == 3'd0 || cnd == 3'd7 || avail) begin
          m_taken = cond_holds(cnd, ca, cb);
          m_pc = m_taken ? pc + off : pc + 16'd1;
          m_res = 1;
        end else begin
          m_pend = 1; p_cond = cnd; p_pc = pc; p_off = off;
        end
      end
      if (we) begin
        la = a; lb = b; m_written = 1;
      end
      if (byp) m_fresh = 1;
      else if (cs) m_fresh = 0;

      tick();
      check("rnd_res_valid", res_valid, {31'd0, m_res});
      if (m_res) begin
        exp_q.push_back({15'd0, m_taken, m_pc});
        check("rnd_result", {15'd0, taken, pc_next}, exp_q.pop_front());
      end
      check("rnd_flags_q", flags_q, m_written ? flags_of(la, lb) : 4'b0000);
    end
    flags_we = 0; cmp_start = 0; br_valid = 0; res_ready = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cond_branch_unit.md
# cond_branch_unit

Consumer side of the 16-bit signed comparator: latches the comparator's four flag outputs and resolves conditional branches against them, producing the taken decision and next PC for the fetch stage. Sits between the ALU/comparator and the program counter. Stalls a branch whose flags are not yet produced, with valid/ready handshakes on both the branch request and the result.

## Interface
- PC_W, 16, program-counter and offset width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flags_in  in  4  comparator flags: [3]=eq, [2]=ne, [1]=ge, [0]=lt (signed)
- flags_we  in  1  flags_in valid this cycle, write to flag register
- cmp_start  in  1  a new compare has been issued; current flags become stale
- br_valid  in  1  branch request valid
- br_ready  out  1  unit can accept a branch
- br_cond  in  3  condition code (see Operation)
- br_offset  in  PC_W  signed two's-complement PC offset
- pc_in  in  PC_W  PC of the branch instruction
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- taken  out  1  branch taken
- pc_next  out  PC_W  next PC
- flags_q  out  4  registered flags

## Operation
- Condition codes: 000 always; 001 eq; 010 ne; 011 ge; 100 lt; 101 gt = ge & ne; 110 le = lt | eq; 111 never.
- Flag register flags_q written on flags_we. flags_ok bit: set by flags_we, cleared by cmp_start; cmp_start and flags_we together → flags_q written, flags_ok = 0.
- Effective flags: flags_in if flags_we & ~cmp_start this cycle (bypass), else flags_q when flags_ok.
- States: IDLE, WAIT, DONE.
  - IDLE: br_ready = 1. Accept on br_valid. If cond ∈ {000,111} or effective flags available → evaluate, go DONE. Else capture cond/offset/pc, go WAIT.
  - WAIT: br_ready = 0. On flags_we & ~cmp_start → evaluate with flags_in, go DONE. Otherwise hold.
  - DONE: br_ready = 0, res_valid = 1; taken/pc_next held stable. On res_ready → IDLE.
- pc_next = taken ? pc + br_offset : pc + 1, truncated to PC_W (modulo 2^PC_W wrap, no overflow flag).
- Branch request fields are registered on accept; later changes to inputs are ignored.

## Timing
- Reset: state IDLE, br_ready = 1, res_valid = 0, taken = 0, pc_next = 0, flags_q = 0000, flags_ok = 0.
- Latency: accept in cycle N with flags available → res_valid high in N+1. In WAIT, flags_we in cycle M → res_valid in M+1.
- Throughput: one branch per two cycles minimum (no accept in DONE, even when res_ready high).
- res_valid holds with stable outputs until res_ready sampled high.
- cmp_start during WAIT: no effect beyond flags_ok; unit keeps waiting for next flags_we.
- Reset asserted mid-operation: immediate return to reset values; pending branch dropped.

## Structure
- Shared package: condition-code constants (COND_AL … COND_NV), flag bit indices (FLAG_EQ=3, FLAG_NE=2, FLAG_GE=1, FLAG_LT=0), state enumeration.
- One sub-module: cond_eval, combinational 4-bit flags + 3-bit cond → taken; reused by the decoder.

## Test plan
- Reset, then br_valid cond=000, pc_in=0x0010, offset=0x0005 → next cycle res_valid=1, taken=1, pc_next=0x0015.
- flags_we flags_in=1010 (eq,ge), later branch cond=001, pc=0x0100, offset=0xFFF0 → taken=1, pc_next=0x00F0; cond=100 → taken=0, pc_next=0x0101.
- cmp_start, then branch cond=101 → br_ready low, stays in WAIT 3 cycles; flags_we 0110 (ne,ge) → res_valid next cycle, taken=1.
- pc_in=0xFFFF, cond=111 → taken=0, pc_next=0x0000; pc_in=0xFFFE, cond=000, offset=0x0004 → pc_next=0x0002.
- res_ready held low 4 cycles in DONE → res_valid, taken, pc_next stable; br_ready 0 throughout; res_ready high → IDLE next cycle.
- Branch in WAIT, rst_n pulsed low → all outputs to reset values, flags_ok=0; subsequent cond=001 branch waits for flags_we.
